// File: rtl/lsu.sv
// Load/store unit: turns an ALU effective address plus rs2 into a
// byte/halfword/word access on a word-addressed data bus with a
// req/gnt/rvalid handshake, and returns aligned, extended load data.
module lsu #(
  parameter int REG_WIDTH  = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  lsu_valid,
  input  logic                  lsu_we,
  input  logic [2:0]            lsu_funct3,
  input  logic [ADDR_WIDTH-1:0] lsu_addr,
  input  logic [REG_WIDTH-1:0]  lsu_wdata,
  output logic                  lsu_busy,
  output logic                  lsu_done,
  output logic                  lsu_err,
  output logic [REG_WIDTH-1:0]  lsu_rdata,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [3:0]            dmem_be,
  output logic [ADDR_WIDTH-1:0] dmem_addr,
  output logic [REG_WIDTH-1:0]  dmem_wdata,
  input  logic                  dmem_gnt,
  input  logic                  dmem_rvalid,
  input  logic [REG_WIDTH-1:0]  dmem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

  state_t                  state_q, state_d;
  logic                    we_q;
  logic [2:0]              f3_q;
  logic [1:0]              alo_q;
  logic                    req_q, dwe_q, done_q, err_q;
  logic [3:0]              be_q;
  logic [ADDR_WIDTH-1:0]   daddr_q;
  logic [REG_WIDTH-1:0]    dwdata_q, rdata_q;
  logic                    accept, bad;

  // 011, 11x, and any store with the unsigned bit set have no meaning.
  function automatic logic illegal_f(input logic we, input logic [2:0] f3);
    return (f3 == 3'b011) || (f3[2:1] == 2'b11) || (we && f3[2]);
  endfunction

  function automatic logic misaligned_f(input logic [2:0] f3, input logic [1:0] a);
    return ((f3[1:0] == 2'b01) && a[0]) || ((f3[1:0] == 2'b10) && (a != 2'b00));
  endfunction

  function automatic logic [3:0] be_f(input logic [2:0] f3, input logic [1:0] a);
    logic [3:0] be;
    case (f3[1:0])
      2'b00:   be = 4'b0001 << a;
      2'b01:   be = 4'b0011 << {a[1], 1'b0};
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // Replicate narrow store data across lanes so the byte enables pick it.
  function automatic logic [REG_WIDTH-1:0] wdata_f(input logic [2:0] f3,
                                                   input logic [REG_WIDTH-1:0] d);
    logic [REG_WIDTH-1:0] w;
    case (f3[1:0])
      2'b00:   w = {4{d[7:0]}};
      2'b01:   w = {2{d[15:0]}};
      default: w = d;
    endcase
    return w;
  endfunction

  function automatic logic [REG_WIDTH-1:0] load_f(input logic [2:0] f3, input logic [1:0] a,
                                                  input logic [REG_WIDTH-1:0] w);
    logic [7:0]                  b;
    logic [15:0]                 h;
    logic signed [7:0]           sb;
    logic signed [15:0]          sh;
    logic signed [REG_WIDTH-1:0] r;
    case (a)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h  = a[1] ? w[31:16] : w[15:0];
    sb = b;
    sh = h;
    case (f3)
      3'b000:  r = REG_WIDTH'(sb);
      3'b100:  r = REG_WIDTH'(b);
      3'b001:  r = REG_WIDTH'(sh);
      3'b101:  r = REG_WIDTH'(h);
      default: r = w;
    endcase
    return r;
  endfunction

  assign accept = (state_q == S_IDLE) && lsu_valid;
  assign bad    = illegal_f(lsu_we, lsu_funct3) || misaligned_f(lsu_funct3, lsu_addr[1:0]);

  // Next-state logic; bad requests skip the bus entirely.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (lsu_valid) state_d = bad ? S_RESP : S_REQ;
      S_REQ:  if (dmem_gnt) state_d = we_q ? S_RESP : S_WAIT;
      S_WAIT: if (dmem_rvalid) state_d = S_RESP;
      default: state_d = S_IDLE;
    endcase
  end

  // State, latched request, and registered bus/response outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      we_q     <= 1'b0;
      f3_q     <= 3'b000;
      alo_q    <= 2'b00;
      req_q    <= 1'b0;
      dwe_q    <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      be_q     <= 4'b0000;
      daddr_q  <= '0;
      dwdata_q <= '0;
      rdata_q  <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= (state_d == S_REQ);
      done_q  <= (state_d == S_RESP);
      // Only the IDLE->RESP path is an error, so err is known at accept.
      err_q   <= accept && bad;
      if (accept) begin
        we_q  <= lsu_we;
        f3_q  <= lsu_funct3;
        alo_q <= lsu_addr[1:0];
        if (!bad) begin
          dwe_q    <= lsu_we;
          be_q     <= be_f(lsu_funct3, lsu_addr[1:0]);
          daddr_q  <= {lsu_addr[ADDR_WIDTH-1:2], 2'b00};
          dwdata_q <= wdata_f(lsu_funct3, lsu_wdata);
        end
      end
      if ((state_q == S_WAIT) && dmem_rvalid)
        rdata_q <= load_f(f3_q, alo_q, dmem_rdata);
    end
  end

  assign lsu_busy   = (state_q != S_IDLE);
  assign lsu_done   = done_q;
  assign lsu_err    = err_q;
  assign lsu_rdata  = rdata_q;
  assign dmem_req   = req_q;
  assign dmem_we    = dwe_q;
  assign dmem_be    = be_q;
  assign dmem_addr  = daddr_q;
  assign dmem_wdata = dwdata_q;

endmodule
